// File: rtl/tl_ul_pkg.sv
// Shared TL-UL types for the register-file slave: channel opcodes, response entry
// and the byte-lane merge helper.
package tl_ul_pkg;

  typedef enum logic [2:0] {
    PUT_FULL    = 3'd0,
    PUT_PARTIAL = 3'd1,
    GET         = 3'd4
  } a_opcode_e;

  typedef enum logic [2:0] {
    ACK      = 3'd0,
    ACK_DATA = 3'd1
  } d_opcode_e;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [31:0] data;
    logic        denied;
  } d_entry_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = mask[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/tl_resp_fifo.sv
// Two-entry response FIFO for channel D; push is refused when full, with no
// bypass from a same-cycle pop.
module tl_resp_fifo
  import tl_ul_pkg::*;
(
  input  logic     clock,
  input  logic     reset,
  input  logic     in_valid,
  output logic     in_ready,
  input  d_entry_t in_entry,
  output logic     out_valid,
  input  logic     out_ready,
  output d_entry_t out_entry
);

  logic [1:0] count_r;
  logic       rd_ptr_r;
  logic       wr_ptr_r;
  d_entry_t   entry_r [2];
  logic       push_s;
  logic       pop_s;

  assign in_ready  = (count_r != 2'd2);
  assign out_valid = (count_r != 2'd0);
  assign out_entry = entry_r[rd_ptr_r];
  assign push_s    = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;

  // Storage, 1-bit wrapping pointers and occupancy count
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_r    <= 2'd0;
      rd_ptr_r   <= 1'b0;
      wr_ptr_r   <= 1'b0;
      entry_r[0] <= '0;
      entry_r[1] <= '0;
    end else begin
      if (push_s) begin
        entry_r[wr_ptr_r] <= in_entry;
        wr_ptr_r          <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/tl_ul_reg_slave.sv
// TL-UL register-file slave: DEPTH x 32 byte-maskable registers behind channel A,
// responses queued in a 2-entry FIFO on channel D.
// Build option: define TL_REG_SLAVE_RANGE_CHECK_EN to deny word indices >= DEPTH
// instead of aliasing them modulo DEPTH.
module tl_ul_reg_slave
  import tl_ul_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        auto_in_a_valid,
  output logic        auto_in_a_ready,
  input  logic [2:0]  auto_in_a_bits_opcode,
  input  logic [6:0]  auto_in_a_bits_address,
  input  logic [3:0]  auto_in_a_bits_mask,
  input  logic [31:0] auto_in_a_bits_data,
  output logic        auto_in_d_valid,
  input  logic        auto_in_d_ready,
  output logic [2:0]  auto_in_d_bits_opcode,
  output logic [31:0] auto_in_d_bits_data,
  output logic        auto_in_d_bits_denied,
  output logic        auto_in_d_bits_corrupt
);

  logic [31:0] regs_r [DEPTH];
  logic [5:0]  word_raw_s;
  logic [5:0]  word_s;
  logic        oob_s;
  logic        is_put_s;
  logic        is_get_s;
  logic        denied_s;
  logic        a_fire_s;
  logic        wr_en_s;
  logic        push_ready_s;
  logic [31:0] rdata_s;
  d_entry_t    push_entry_s;
  d_entry_t    head_s;

  // Byte-address bits [1:0] fall away in the shift
  assign word_raw_s = 6'(auto_in_a_bits_address >> 2);

`ifdef TL_REG_SLAVE_RANGE_CHECK_EN
  assign word_s = word_raw_s;
  assign oob_s  = (word_raw_s >= 6'(DEPTH));
`else
  assign word_s = word_raw_s % 6'(DEPTH);
  assign oob_s  = 1'b0;
`endif

  assign auto_in_a_ready = reset & push_ready_s;
  assign a_fire_s        = auto_in_a_valid & auto_in_a_ready;
  assign denied_s        = ~(is_put_s | is_get_s) | oob_s;
  assign wr_en_s         = a_fire_s & is_put_s & ~oob_s;

  // Opcode decode, read mux and response entry construction
  always_comb begin
    is_put_s     = 1'b0;
    is_get_s     = 1'b0;
    rdata_s      = 32'h0000_0000;
    push_entry_s = '0;
    case (auto_in_a_bits_opcode)
      PUT_FULL, PUT_PARTIAL: is_put_s = 1'b1;
      GET:                   is_get_s = 1'b1;
      default:               is_put_s = 1'b0;
    endcase
    for (int i = 0; i < DEPTH; i++) begin
      rdata_s = (word_s == 6'(i)) ? regs_r[i] : rdata_s;
    end
    push_entry_s.opcode = is_get_s ? ACK_DATA : ACK;
    push_entry_s.data   = (is_get_s & ~denied_s) ? rdata_s : 32'h0000_0000;
    push_entry_s.denied = denied_s;
  end

  // Register array with byte-lane writes on an accepted Put
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en_s && (word_s == 6'(i))) begin
          regs_r[i] <= merge_bytes(regs_r[i], auto_in_a_bits_data, auto_in_a_bits_mask);
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end
    end
  end

  tl_resp_fifo u_resp_fifo (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (auto_in_a_valid & reset),
    .in_ready  (push_ready_s),
    .in_entry  (push_entry_s),
    .out_valid (auto_in_d_valid),
    .out_ready (auto_in_d_ready),
    .out_entry (head_s)
  );

  assign auto_in_d_bits_opcode  = head_s.opcode;
  assign auto_in_d_bits_data    = head_s.data;
  assign auto_in_d_bits_denied  = head_s.denied;
  assign auto_in_d_bits_corrupt = head_s.denied & (head_s.opcode == ACK_DATA);

endmodule

// File: tb/tb_tl_ul_reg_slave.sv
// Directed, table-driven bench for tl_ul_reg_slave (DEPTH=16, RESET_VAL=0),
// with hand-written sequences for latency, backpressure and mid-transfer reset.
module tb_tl_ul_reg_slave;

  logic        clock;
  logic        reset;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [6:0]  a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [31:0] d_data;
  logic        d_denied;
  logic        d_corrupt;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2:0]  op;
    logic [6:0]  addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [2:0]  e_op;
    logic [31:0] e_data;
    logic        e_den;
    logic        e_cor;
  } vec_t;

  vec_t vecs [16];

  tl_ul_reg_slave #(.DEPTH(16), .RESET_VAL(32'h0000_0000)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .auto_in_a_valid        (a_valid),
    .auto_in_a_ready        (a_ready),
    .auto_in_a_bits_opcode  (a_opcode),
    .auto_in_a_bits_address (a_address),
    .auto_in_a_bits_mask    (a_mask),
    .auto_in_a_bits_data    (a_data),
    .auto_in_d_valid        (d_valid),
    .auto_in_d_ready        (d_ready),
    .auto_in_d_bits_opcode  (d_opcode),
    .auto_in_d_bits_data    (d_data),
    .auto_in_d_bits_denied  (d_denied),
    .auto_in_d_bits_corrupt (d_corrupt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (time %0t, limit 500000)", $time);
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [2:0] op, input logic [6:0] addr,
                              input logic [3:0] mask, input logic [31:0] data,
                              input logic [2:0] e_op, input logic [31:0] e_data,
                              input logic e_den, input logic e_cor);
    vec_t v;
    v.op = op; v.addr = addr; v.mask = mask; v.data = data;
    v.e_op = e_op; v.e_data = e_data; v.e_den = e_den; v.e_cor = e_cor;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Called one time unit after a rising edge; returns after the A fire edge.
  task automatic send(input logic [2:0] op, input logic [6:0] addr,
                      input logic [3:0] mask, input logic [31:0] data);
    a_valid = 1'b1; a_opcode = op; a_address = addr; a_mask = mask; a_data = data;
    for (int n = 0; n < 50 && !a_ready; n++) tick();
    if (!a_ready) begin
      tests++; fails++;
      $display("FAIL a_ready_timeout: got 0, expected 1 within 50 cycles");
    end
    tick();
    a_valid = 1'b0;
  endtask

  task automatic recv(output logic [2:0] op, output logic [31:0] data,
                      output logic den, output logic cor);
    d_ready = 1'b1;
    for (int n = 0; n < 50 && !d_valid; n++) tick();
    if (!d_valid) begin
      tests++; fails++;
      $display("FAIL d_valid_timeout: got 0, expected 1 within 50 cycles");
    end
    op = d_opcode; data = d_data; den = d_denied; cor = d_corrupt;
    tick();
    d_ready = 1'b0;
  endtask

  logic [2:0]  r_op;
  logic [31:0] r_data;
  logic        r_den;
  logic        r_cor;
  logic [31:0] exp_idx15;

  initial begin
`ifdef TL_REG_SLAVE_RANGE_CHECK_EN
    exp_idx15 = 32'h0F0F_1234;
`else
    exp_idx15 = 32'hCAFE_F00D;
`endif
    vecs[0]  = mk(3'd4, 7'h04, 4'h0, 32'h0000_0000, 3'd1, 32'h0000_0000, 1'b0, 1'b0);
    vecs[1]  = mk(3'd0, 7'h08, 4'hF, 32'hDEAD_BEEF, 3'd0, 32'h0000_0000, 1'b0, 1'b0);
    vecs[2]  = mk(3'd4, 7'h08, 4'h0, 32'h0000_0000, 3'd1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    vecs[3]  = mk(3'd1, 7'h08, 4'h5, 32'h1122_3344, 3'd0, 32'h0000_0000, 1'b0, 1'b0);
    vecs[4]  = mk(3'd4, 7'h08, 4'h0, 32'h0000_0000, 3'd1, 32'hDE22_BE44, 1'b0, 1'b0);
    vecs[5]  = mk(3'd0, 7'h00, 4'hF, 32'hA5A5_A5A5, 3'd0, 32'h0000_0000, 1'b0, 1'b0);
    vecs[6]  = mk(3'd2, 7'h00, 4'hF, 32'hFFFF_FFFF, 3'd0, 32'h0000_0000, 1'b1, 1'b0);
    vecs[7]  = mk(3'd4, 7'h00, 4'h0, 32'h0000_0000, 3'd1, 32'hA5A5_A5A5, 1'b0, 1'b0);
    vecs[8]  = mk(3'd7, 7'h00, 4'hF, 32'h1234_5678, 3'd0, 32'h0000_0000, 1'b1, 1'b0);
    vecs[9]  = mk(3'd0, 7'h3C, 4'hF, 32'h0F0F_1234, 3'd0, 32'h0000_0000, 1'b0, 1'b0);
`ifdef TL_REG_SLAVE_RANGE_CHECK_EN
    vecs[10] = mk(3'd4, 7'h7C, 4'h0, 32'h0000_0000, 3'd1, 32'h0000_0000, 1'b1, 1'b1);
    vecs[11] = mk(3'd0, 7'h7C, 4'hF, 32'hCAFE_F00D, 3'd0, 32'h0000_0000, 1'b1, 1'b0);
`else
    vecs[10] = mk(3'd4, 7'h7C, 4'h0, 32'h0000_0000, 3'd1, 32'h0F0F_1234, 1'b0, 1'b0);
    vecs[11] = mk(3'd0, 7'h7C, 4'hF, 32'hCAFE_F00D, 3'd0, 32'h0000_0000, 1'b0, 1'b0);
`endif
    vecs[12] = mk(3'd4, 7'h3C, 4'h0, 32'h0000_0000, 3'd1, exp_idx15,     1'b0, 1'b0);
    vecs[13] = mk(3'd4, 7'h0B, 4'h0, 32'h0000_0000, 3'd1, 32'hDE22_BE44, 1'b0, 1'b0);
    vecs[14] = mk(3'd1, 7'h10, 4'h8, 32'hFFFF_FFFF, 3'd0, 32'h0000_0000, 1'b0, 1'b0);
    vecs[15] = mk(3'd4, 7'h10, 4'h0, 32'h0000_0000, 3'd1, 32'hFF00_0000, 1'b0, 1'b0);

    reset = 1'b0; a_valid = 1'b0; d_ready = 1'b0;
    a_opcode = 3'd0; a_address = 7'h00; a_mask = 4'h0; a_data = 32'h0000_0000;

    // Reset state
    tick(); tick();
    check("rst_a_ready", 32'(a_ready), 32'd0);
    check("rst_d_valid", 32'(d_valid), 32'd0);
    check("rst_d_opcode", 32'(d_opcode), 32'd0);
    check("rst_d_data", d_data, 32'h0000_0000);
    check("rst_d_denied", 32'(d_denied), 32'd0);
    check("rst_d_corrupt", 32'(d_corrupt), 32'd0);
    reset = 1'b1;
    tick();
    check("post_rst_a_ready", 32'(a_ready), 32'd1);
    check("post_rst_d_valid", 32'(d_valid), 32'd0);

    // Table-driven single transactions
    for (int i = 0; i < 16; i++) begin
      send(vecs[i].op, vecs[i].addr, vecs[i].mask, vecs[i].data);
      recv(r_op, r_data, r_den, r_cor);
      check($sformatf("v%0d_opcode", i), 32'(r_op), 32'(vecs[i].e_op));
      check($sformatf("v%0d_data", i), r_data, vecs[i].e_data);
      check($sformatf("v%0d_denied", i), 32'(r_den), 32'(vecs[i].e_den));
      check($sformatf("v%0d_corrupt", i), 32'(r_cor), 32'(vecs[i].e_cor));
    end

    // Put then Get to the same word on consecutive cycles, d_ready held high
    d_ready = 1'b1;
    a_valid = 1'b1; a_opcode = 3'd0; a_address = 7'h14; a_mask = 4'hF; a_data = 32'h1234_5678;
    check("b2b_a_ready", 32'(a_ready), 32'd1);
    tick();
    check("b2b_latency_d_valid", 32'(d_valid), 32'd1);
    check("b2b_put_ack_opcode", 32'(d_opcode), 32'd0);
    a_opcode = 3'd4; a_mask = 4'h0; a_data = 32'h0000_0000;
    tick();
    a_valid = 1'b0;
    check("b2b_get_d_valid", 32'(d_valid), 32'd1);
    check("b2b_get_opcode", 32'(d_opcode), 32'd1);
    check("b2b_get_data", d_data, 32'h1234_5678);
    tick();
    d_ready = 1'b0;
    check("b2b_drained", 32'(d_valid), 32'd0);

    // Three back-to-back Gets against a stalled D channel
    a_valid = 1'b1; a_opcode = 3'd4; a_address = 7'h00; a_mask = 4'h0;
    tick();
    a_address = 7'h08;
    tick();
    a_address = 7'h3C;
    check("bp_third_blocked", 32'(a_ready), 32'd0);
    check("bp_head_data", d_data, 32'hA5A5_A5A5);
    tick();
    check("bp_still_blocked", 32'(a_ready), 32'd0);
    check("bp_head_stable", d_data, 32'hA5A5_A5A5);
    d_ready = 1'b1;
    check("bp_no_bypass", 32'(a_ready), 32'd0);
    tick();
    check("bp_ready_after_pop", 32'(a_ready), 32'd1);
    check("bp_second_opcode", 32'(d_opcode), 32'd1);
    check("bp_second_data", d_data, 32'hDE22_BE44);
    tick();
    a_valid = 1'b0;
    check("bp_third_d_valid", 32'(d_valid), 32'd1);
    check("bp_third_data", d_data, exp_idx15);
    tick();
    d_ready = 1'b0;
    check("bp_drained", 32'(d_valid), 32'd0);

    // Reset while responses are queued
    a_valid = 1'b1; a_opcode = 3'd4; a_address = 7'h08;
    tick(); tick();
    a_valid = 1'b0;
    check("mid_queued", 32'(d_valid), 32'd1);
    reset = 1'b0;
    #2;
    check("mid_rst_d_valid", 32'(d_valid), 32'd0);
    check("mid_rst_a_ready", 32'(a_ready), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    check("mid_after_d_valid", 32'(d_valid), 32'd0);
    send(3'd4, 7'h08, 4'h0, 32'h0000_0000);
    recv(r_op, r_data, r_den, r_cor);
    check("mid_reg_reset_opcode", 32'(r_op), 32'd1);
    check("mid_reg_reset_data", r_data, 32'h0000_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
